shapool_master: RTL and testbench

SHAPOOL_MASTER -- requirements
Module: shapool_master

---
 rtl/shapool_pkg.sv | 28 ++
 rtl/shapool_sclk_gen.sv | 40 ++++
 rtl/shapool_master.sv | 179 +++++++++++++++++
 tb/tb_shapool_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shapool_pkg.sv
// Shared definitions for the SHA pool master: FSM encoding, default sizes and
// a small sizing helper for the bit counter.
package shapool_pkg;

  localparam int unsigned JOB_BITS_DEF    = 352;
  localparam int unsigned DAISY_BITS_DEF  = 8;
  localparam int unsigned N_DEV_DEF       = 2;
  localparam int unsigned RESULT_BITS_DEF = 40;
  localparam int unsigned CLK_HALF_DEF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_JOB,
    ST_LOAD_DAISY,
    ST_RUN,
    ST_READ,
    ST_FINISH
  } state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/shapool_sclk_gen.sv
// Serial bit timer: each bit is CLK_HALF cycles of data_clk low, then
// CLK_HALF cycles high. Idles low with the phase cleared while run is low.
module shapool_sclk_gen #(
  parameter int unsigned CLK_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic data_clk,
  output logic fall_strobe,
  output logic sample_strobe
);

  localparam int unsigned PW = $clog2(2 * CLK_HALF);
  localparam logic [PW-1:0] LAST = PW'(2 * CLK_HALF - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_HALF);

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;

  always_comb begin
    phase_nxt = (phase == LAST) ? '0 : phase + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      phase    <= '0;
      data_clk <= 1'b0;
    end else begin
      phase    <= phase_nxt;
      data_clk <= (phase_nxt >= HALF);
    end
  end

  // Both strobes mark the last high cycle of a bit: the edge closing it is
  // where the receiver samples and where the transmitter presents the next bit.
  assign fall_strobe   = run && (phase == LAST);
  assign sample_strobe = run && data_clk && (phase == LAST);

endmodule

// File: rtl/shapool_master.sv
// Master for a daisy-chained SHA pool: loads the job and the per-device
// daisy configuration serially, waits for done, then reads back the result.
module shapool_master
  import shapool_pkg::*;
#(
  parameter int unsigned JOB_BITS    = JOB_BITS_DEF,
  parameter int unsigned DAISY_BITS  = DAISY_BITS_DEF,
  parameter int unsigned N_DEV       = N_DEV_DEF,
  parameter int unsigned RESULT_BITS = RESULT_BITS_DEF,
  parameter int unsigned CLK_HALF    = CLK_HALF_DEF
) (
  input  logic                        hwclk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [JOB_BITS-1:0]         job,
  input  logic [N_DEV*DAISY_BITS-1:0] daisy_cfg,
  output logic                        busy,
  output logic                        pool_reset,
  output logic                        data_clk,
  output logic                        data_out,
  input  logic                        data_in,
  output logic                        daisy_sel,
  output logic                        daisy_out,
  input  logic                        done_in,
  input  logic                        success_in,
  output logic [RESULT_BITS-1:0]      result,
  output logic                        result_valid,
  output logic                        result_success
);

  localparam int unsigned CFG_BITS = N_DEV * DAISY_BITS;
  localparam int unsigned CNT_W    = $clog2(max3(JOB_BITS, CFG_BITS, RESULT_BITS) + 1);
  localparam logic [CNT_W-1:0] JOB_LAST = CNT_W'(JOB_BITS - 1);
  localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(CFG_BITS - 1);
  localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RESULT_BITS - 1);

  state_t                 state;
  logic [JOB_BITS-1:0]    job_sr;
  logic [CFG_BITS-1:0]    cfg_sr;
  logic [RESULT_BITS-1:0] res_sr;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   succ_hold;
  logic [1:0]             data_sync, done_sync, succ_sync;
  logic                   data_s, done_s, succ_s;
  logic                   gen_run, fall_strobe, sample_strobe;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      data_sync <= '0;
      done_sync <= '0;
      succ_sync <= '0;
    end else begin
      data_sync <= {data_sync[0], data_in};
      done_sync <= {done_sync[0], done_in};
      succ_sync <= {succ_sync[0], success_in};
    end
  end

  assign data_s = data_sync[1];
  assign done_s = done_sync[1];
  assign succ_s = succ_sync[1];

  // Abort gates the bit timer directly so data_clk is low on the cycle after abort.
  assign gen_run = !abort && (state inside {ST_LOAD_JOB, ST_LOAD_DAISY, ST_READ});
  assign busy    = (state != ST_IDLE);

  shapool_sclk_gen #(
    .CLK_HALF(CLK_HALF)
  ) u_sclk_gen (
    .clk          (hwclk),
    .reset        (reset),
    .run          (gen_run),
    .data_clk     (data_clk),
    .fall_strobe  (fall_strobe),
    .sample_strobe(sample_strobe)
  );

  // Handshake: start is accepted only in IDLE and only without abort; result_valid
  // is a one-cycle pulse with result/result_success stable from that cycle on.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state          <= ST_IDLE;
      pool_reset     <= 1'b1;
      data_out       <= 1'b0;
      daisy_sel      <= 1'b0;
      daisy_out      <= 1'b0;
      result         <= '0;
      result_valid   <= 1'b0;
      result_success <= 1'b0;
      succ_hold      <= 1'b0;
      job_sr         <= '0;
      cfg_sr         <= '0;
      res_sr         <= '0;
      bit_cnt        <= '0;
    end else begin
      result_valid <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state      <= ST_IDLE;
        pool_reset <= 1'b1;
        data_out   <= 1'b0;
        daisy_sel  <= 1'b0;
        daisy_out  <= 1'b0;
        bit_cnt    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              job_sr     <= job << 1;
              cfg_sr     <= daisy_cfg;
              data_out   <= job[JOB_BITS-1];
              daisy_sel  <= 1'b0;
              daisy_out  <= 1'b0;
              pool_reset <= 1'b1;
              bit_cnt    <= '0;
              state      <= ST_LOAD_JOB;
            end
          end
          ST_LOAD_JOB: begin
            if (fall_strobe) begin
              if (bit_cnt == JOB_LAST) begin
                bit_cnt   <= '0;
                data_out  <= 1'b0;
                daisy_sel <= 1'b1;
                daisy_out <= cfg_sr[CFG_BITS-1];
                cfg_sr    <= cfg_sr << 1;
                state     <= ST_LOAD_DAISY;
              end else begin
                bit_cnt  <= bit_cnt + CNT_W'(1);
                data_out <= job_sr[JOB_BITS-1];
                job_sr   <= job_sr << 1;
              end
            end
          end
          ST_LOAD_DAISY: begin
            if (fall_strobe) begin
              if (bit_cnt == CFG_LAST) begin
                bit_cnt    <= '0;
                pool_reset <= 1'b0;
                daisy_sel  <= 1'b0;
                daisy_out  <= 1'b0;
                state      <= ST_RUN;
              end else begin
                bit_cnt   <= bit_cnt + CNT_W'(1);
                daisy_out <= cfg_sr[CFG_BITS-1];
                cfg_sr    <= cfg_sr << 1;
              end
            end
          end
          ST_RUN: begin
            if (done_s) begin
              succ_hold <= succ_s;
              res_sr    <= '0;
              bit_cnt   <= '0;
              state     <= ST_READ;
            end
          end
          ST_READ: begin
            if (sample_strobe) begin
              res_sr <= (res_sr << 1) | RESULT_BITS'(data_s);
              if (bit_cnt == RES_LAST) begin
                result         <= (res_sr << 1) | RESULT_BITS'(data_s);
                result_success <= succ_hold;
                result_valid   <= 1'b1;
                pool_reset     <= 1'b1;
                state          <= ST_FINISH;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          ST_FINISH: state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shapool_master.sv
// Randomized scoreboard bench for shapool_master with a serial pool model.
module tb_shapool_master;

  localparam int JOB_BITS    = 352;
  localparam int DAISY_BITS  = 8;
  localparam int N_DEV       = 2;
  localparam int RESULT_BITS = 40;
  localparam int CLK_HALF    = 4;
  localparam int CFG_BITS    = N_DEV * DAISY_BITS;
  localparam int LOAD_CYCLES = (JOB_BITS + CFG_BITS) * 2 * CLK_HALF;

  // clock / reset / DUT
  logic                   hwclk = 1'b0;
  logic                   reset, start, abort;
  logic [JOB_BITS-1:0]    job;
  logic [CFG_BITS-1:0]    daisy_cfg;
  logic                   busy, pool_reset, data_clk, data_out;
  logic                   data_in, daisy_sel, daisy_out, done_in, success_in;
  logic [RESULT_BITS-1:0] result;
  logic                   result_valid, result_success;

  always #5 hwclk = ~hwclk;

  shapool_master dut (
    .hwclk         (hwclk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .job           (job),
    .daisy_cfg     (daisy_cfg),
    .busy          (busy),
    .pool_reset    (pool_reset),
    .data_clk      (data_clk),
    .data_out      (data_out),
    .data_in       (data_in),
    .daisy_sel     (daisy_sel),
    .daisy_out     (daisy_out),
    .done_in       (done_in),
    .success_in    (success_in),
    .result        (result),
    .result_valid  (result_valid),
    .result_success(result_success)
  );

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [1:0]           exp_bit_q[$];
  logic [RESULT_BITS:0] exp_res_q[$];
  int n_valid = 0;
  int n_starts = 0;
  int load_rises = 0;
  logic p_dclk = 1'b0, p_dout = 1'b0, p_dyout = 1'b0, p_busy = 1'b0;
  int hi_len = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got an event, expected none queued", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  // reference model: serial stream is the job MSB first, then the flat daisy vector MSB first
  task automatic push_job(input logic [JOB_BITS-1:0] j, input logic [CFG_BITS-1:0] c);
    for (int i = JOB_BITS - 1; i >= 0; i--) exp_bit_q.push_back({1'b0, j[i]});
    for (int i = CFG_BITS - 1; i >= 0; i--) exp_bit_q.push_back({1'b1, c[i]});
  endtask

  function automatic logic [JOB_BITS-1:0] rand_job();
    logic [JOB_BITS-1:0] j;
    for (int i = 0; i < JOB_BITS / 32; i++) j[i*32 +: 32] = $urandom;
    return j;
  endfunction

  function automatic logic [RESULT_BITS-1:0] rand_word();
    return {8'($urandom_range(0, 255)), 32'($urandom)};
  endfunction

  task automatic monitor_loop();
    logic [1:0]           e;
    logic [RESULT_BITS:0] er;
    forever begin
      @(negedge hwclk);
      if (busy && !p_busy) n_starts++;
      if (busy && pool_reset && data_clk && !p_dclk) begin
        load_rises++;
        if (exp_bit_q.size() == 0) fail_now("unexpected_load_bit");
        else begin
          e = exp_bit_q.pop_front();
          check("load_bit", 64'({daisy_sel, daisy_sel ? daisy_out : data_out}), 64'(e));
        end
      end
      if (busy && p_busy && (data_out !== p_dout || daisy_out !== p_dyout))
        check("tx_on_fall", 64'({p_dclk, data_clk}), 64'(2'b10));
      if (busy && p_dclk && !data_clk) check("high_len", 64'(hi_len), 64'(CLK_HALF));
      hi_len = data_clk ? hi_len + 1 : 0;
      if (result_valid) begin
        n_valid++;
        if (exp_res_q.size() == 0) fail_now("unexpected_result");
        else begin
          er = exp_res_q.pop_front();
          check("result", 64'({result_success, result}), 64'(er));
        end
      end
      p_dclk  = data_clk;
      p_dout  = data_out;
      p_dyout = daisy_out;
      p_busy  = busy;
    end
  endtask

  // driver tasks
  task automatic start_job(input logic [JOB_BITS-1:0] j, input logic [CFG_BITS-1:0] c,
                           input bit hold);
    job = j;
    daisy_cfg = c;
    start = 1'b1;
    push_job(j, c);
    tick(1);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (pool_reset && n < LOAD_CYCLES + 200) begin
      tick(1);
      n++;
    end
    check("reach_run", 64'(pool_reset), 64'(0));
  endtask

  // pool model: assert done after a delay, shift the word MSB first, one bit per data_clk period
  task automatic pool_respond(input logic [RESULT_BITS-1:0] w, input logic s,
                              input int delay, input bit expect_idle);
    int n, idx, v0;
    logic pd;
    wait_run();
    v0 = n_valid;
    tick(delay);
    check("run_hold", 64'({busy, pool_reset, data_clk, data_out, daisy_sel}), 64'(5'b10000));
    check("no_early_result", 64'(n_valid), 64'(v0));
    exp_res_q.push_back({s, w});
    data_in = w[RESULT_BITS-1];
    success_in = s;
    done_in = 1'b1;
    idx = 0;
    pd = data_clk;
    n = 0;
    while (n_valid == v0 && n < RESULT_BITS * 2 * CLK_HALF + 50) begin
      tick(1);
      n++;
      if (pd && !data_clk && idx < RESULT_BITS - 1) begin
        idx++;
        data_in = w[RESULT_BITS-1-idx];
      end
      pd = data_clk;
    end
    done_in = 1'b0;
    success_in = 1'b0;
    data_in = 1'b0;
    check("valid_seen", 64'(n_valid), 64'(v0 + 1));
    tick(3);
    check("valid_single", 64'(n_valid), 64'(v0 + 1));
    check("result_hold", 64'(result), 64'(w));
    if (expect_idle) check("idle_after", 64'({busy, pool_reset}), 64'(2'b01));
  endtask

  initial begin
    logic [JOB_BITS-1:0]    ja, jb;
    logic [CFG_BITS-1:0]    ca, cb;
    logic [RESULT_BITS-1:0] wa, wb;
    int n, first, r0, s0, v0;

    reset = 1'b1; start = 1'b0; abort = 1'b0; job = '0; daisy_cfg = '0;
    data_in = 1'b0; done_in = 1'b0; success_in = 1'b0;
    tick(3);
    check("reset_outputs",
          64'({busy, pool_reset, data_clk, data_out, daisy_sel, daisy_out, result_valid, result_success}),
          64'(8'b01000000));
    check("reset_result", 64'(result), 64'(0));
    reset = 1'b0;
    fork
      monitor_loop();
    join_none
    tick(2);

    // fixed job with A55A daisy, latency and load length, then DEADBEEF readback
    ja = 352'h123456789ABCDEF0_123456789ABCDEF0_123456789ABCDEF0_123456789ABCDEF0_123456789ABCDEF0_5A5AABCD;
    r0 = load_rises;
    job = ja; daisy_cfg = 16'hA55A; start = 1'b1;
    push_job(ja, 16'hA55A);
    n = 0; first = 0;
    while (n < LOAD_CYCLES + 100) begin
      tick(1);
      n++;
      if (n == 1) start = 1'b0;
      if (data_clk && first == 0) first = n;
      if (!pool_reset) break;
    end
    check("first_rise_latency", 64'(first), 64'(CLK_HALF + 1));
    check("load_cycles", 64'(n), 64'(LOAD_CYCLES + 1));
    check("load_rise_count", 64'(load_rises - r0), 64'(JOB_BITS + CFG_BITS));
    check("bits_drained", 64'(exp_bit_q.size()), 64'(0));
    pool_respond(40'h00DEADBEEF, 1'b1, 5, 1'b1);

    // random jobs, results and done delays
    for (int k = 0; k < 3; k++) begin
      start_job(rand_job(), 16'($urandom), 1'b0);
      pool_respond(rand_word(), 1'($urandom_range(0, 1)), $urandom_range(0, 20), 1'b1);
    end

    // abort at bit 100 of the job load
    v0 = n_valid; r0 = load_rises;
    start_job(rand_job(), 16'($urandom), 1'b0);
    n = 0;
    while (load_rises - r0 < 100 && n < 2000) begin
      tick(1);
      n++;
    end
    check("abort_reached_bit100", 64'(load_rises - r0), 64'(100));
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_state", 64'({busy, pool_reset, data_clk}), 64'(3'b010));
    exp_bit_q.delete();
    tick(50);
    check("abort_no_result", 64'(n_valid), 64'(v0));
    check("abort_stays_idle", 64'(busy), 64'(0));

    // abort and start together in IDLE: nothing starts
    s0 = n_starts;
    job = rand_job(); start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(3);
    check("abort_beats_start", 64'(n_starts - s0), 64'(0));

    // start held high across a whole job: second job only after IDLE, with the new inputs
    s0 = n_starts;
    ja = rand_job(); jb = rand_job(); ca = 16'($urandom); cb = 16'($urandom);
    wa = rand_word(); wb = rand_word();
    start_job(ja, ca, 1'b1);
    push_job(jb, cb);
    tick(5);
    job = jb; daisy_cfg = cb;
    wait_run();
    check("held_start_one_job", 64'(n_starts - s0), 64'(1));
    pool_respond(wa, 1'b1, 5, 1'b0);
    n = 0;
    while (n_starts - s0 < 2 && n < 50) begin
      tick(1);
      n++;
    end
    check("restart_after_idle", 64'(n_starts - s0), 64'(2));
    start = 1'b0;
    pool_respond(wb, 1'b0, 10, 1'b1);
    check("held_start_total", 64'(n_starts - s0), 64'(2));

    // done pulsed during the job load is ignored
    start_job(rand_job(), 16'($urandom), 1'b0);
    tick(60);
    done_in = 1'b1; success_in = 1'b1;
    tick(4);
    done_in = 1'b0; success_in = 1'b0;
    pool_respond(rand_word(), 1'b0, 40, 1'b1);

    // reset in the middle of READ leaves no result
    v0 = n_valid;
    start_job(rand_job(), 16'($urandom), 1'b0);
    wait_run();
    data_in = 1'b1; success_in = 1'b1; done_in = 1'b1;
    tick(40);
    reset = 1'b1;
    tick(2);
    check("midread_reset_outputs",
          64'({busy, pool_reset, data_clk, data_out, daisy_sel, daisy_out, result_valid, result_success}),
          64'(8'b01000000));
    check("midread_reset_result", 64'(result), 64'(0));
    reset = 1'b0; data_in = 1'b0; success_in = 1'b0; done_in = 1'b0;
    tick(60);
    check("midread_no_valid", 64'(n_valid), 64'(v0));

    check("final_bits_queue", 64'(exp_bit_q.size()), 64'(0));
    check("final_result_queue", 64'(exp_res_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
